rv_multicycle_ctrl: RTL and testbench

Main control FSM for the RV32I multi-cycle core. It sequences fetch, decode, execute, memory and writeback, and drives the datapath selects. This includes the format select for the immediate generator. It owns the memory request/ack handshake, including a bounded wait timeout. It sits between the instruction register / immediate generator and the PC, ALU, register file and memory-port muxes.

---
 rtl/rv_ctrl_pkg.sv | 56 +++++
 rtl/rv_multicycle_ctrl_if.sv | 12 +
 rtl/rv_opcode_class.sv | 29 ++
 rtl/rv_multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and select codes for the RV32I multi-cycle control path.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BR     = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
    } op_class_t;

    localparam logic [1:0] PC_SRC_PC4   = 2'd0;
    localparam logic [1:0] PC_SRC_ALU   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR  = 2'd2;

    localparam logic [1:0] SRC_A_RS1    = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_ZERO   = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_BR    = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [1:0] WB_SEL_MEM   = 2'd1;
    localparam logic [1:0] WB_SEL_PC4   = 2'd2;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Memory-port handshake between the control FSM (master) and the memory (slave).
interface rv_multicycle_ctrl_if;
    // mem_req is held high until the cycle with mem_req && mem_ack, which completes
    // the transfer; the only other way a request ends is the controller's timeout abort.
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/rv_opcode_class.sv
// Combinational opcode decode: instruction class, immediate format and legality.
module rv_opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output imm_sel_t   o_imm_sel,
    output logic       o_legal
);

    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_imm_sel = IMM_I;
        case (i_opcode)
            OPC_R:     o_class = CLS_R;
            OPC_I:     o_class = CLS_I;
            OPC_LOAD:  o_class = CLS_LOAD;
            OPC_STORE: begin o_class = CLS_STORE;  o_imm_sel = IMM_S; end
            OPC_BR:    begin o_class = CLS_BRANCH; o_imm_sel = IMM_B; end
            OPC_JAL:   begin o_class = CLS_JAL;    o_imm_sel = IMM_J; end
            OPC_JALR:  o_class = CLS_JALR;
            OPC_LUI:   begin o_class = CLS_LUI;    o_imm_sel = IMM_U; end
            OPC_AUIPC: begin o_class = CLS_AUIPC;  o_imm_sel = IMM_U; end
            default:   o_class = CLS_ILLEGAL;
        endcase
        o_legal = (o_class != CLS_ILLEGAL);
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the RV32I multi-cycle core with bounded memory wait.
// Optional: define ILLEGAL_TRAP_EN to park the FSM in TRAP on an illegal opcode.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_instruction,
    input  logic            i_branch_taken,
    rv_multicycle_ctrl_if.master bus,
    output logic            o_ir_write,
    output logic            o_pc_write,
    output logic [1:0]      o_pc_src,
    output logic [2:0]      o_imm_sel,
    output logic [1:0]      o_alu_src_a,
    output logic [1:0]      o_alu_src_b,
    output logic [1:0]      o_alu_op,
    output logic            o_reg_write,
    output logic [1:0]      o_wb_sel,
    output logic            o_bus_err,
    output logic [2:0]      o_state
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_wait_cnt;
    op_class_t   w_class;
    imm_sel_t    w_cls_imm;
    logic        w_legal;
    logic        w_timeout;
    logic        w_waiting;
    logic        w_mem_req, w_mem_we, w_addr_sel, w_ir_write, w_pc_write;
    logic        w_reg_write, w_bus_err;
    logic [1:0]  w_pc_src, w_src_a, w_src_b, w_alu_op, w_wb_sel;
    logic [2:0]  w_imm_sel;
    logic        w_unused_instr;

    assign w_unused_instr = ^i_instruction[XLEN-1:7];

    rv_opcode_class u_opcode_class (
        .i_opcode  (i_instruction[6:0]),
        .o_class   (w_class),
        .o_imm_sel (w_cls_imm),
        .o_legal   (w_legal)
    );

    // An ack on the final allowed wait cycle completes the transfer instead of aborting.
    assign w_timeout = (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) && !bus.mem_ack;
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ack && !w_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_waiting ? r_wait_cnt + 16'd1 : 16'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_SRC_PC4;
        w_imm_sel    = 3'(IMM_I);
        w_src_a      = SRC_A_RS1;
        w_src_b      = SRC_B_RS2;
        w_alu_op     = ALU_OP_ADD;
        w_reg_write  = 1'b0;
        w_wb_sel     = WB_SEL_ALU;
        w_bus_err    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                w_imm_sel = 3'(w_cls_imm);
                if (w_legal) begin
                    w_state_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    w_state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                w_imm_sel    = 3'(w_cls_imm);
                w_src_b      = SRC_B_IMM;
                w_state_next = S_WB;
                case (w_class)
                    CLS_R: begin
                        w_src_b  = SRC_B_RS2;
                        w_alu_op = ALU_OP_FUNCT;
                    end
                    CLS_I: w_alu_op = ALU_OP_FUNCT;
                    CLS_LOAD, CLS_STORE: w_state_next = S_MEM;
                    CLS_BRANCH: begin
                        w_src_a      = SRC_A_OLD_PC;
                        w_pc_write   = i_branch_taken;
                        w_pc_src     = i_branch_taken ? PC_SRC_ALU : PC_SRC_PC4;
                        w_state_next = S_FETCH;
                    end
                    CLS_JAL: begin
                        w_src_a    = SRC_A_OLD_PC;
                        w_pc_write = 1'b1;
                        w_pc_src   = PC_SRC_ALU;
                    end
                    CLS_JALR: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = PC_SRC_JALR;
                    end
                    CLS_LUI:   w_src_a = SRC_A_ZERO;
                    CLS_AUIPC: w_src_a = SRC_A_OLD_PC;
                    default:   w_state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_imm_sel  = 3'(w_cls_imm);
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (w_class == CLS_STORE);
                if (bus.mem_ack) begin
                    w_state_next = (w_class == CLS_LOAD) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_bus_err    = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_WB: begin
                w_imm_sel    = 3'(w_cls_imm);
                w_reg_write  = 1'b1;
                w_state_next = S_FETCH;
                if (w_class == CLS_LOAD) begin
                    w_wb_sel = WB_SEL_MEM;
                end else if ((w_class == CLS_JAL) || (w_class == CLS_JALR)) begin
                    w_wb_sel = WB_SEL_PC4;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: w_state_next = S_TRAP;
`endif
            default: w_state_next = S_FETCH;
        endcase
    end

    // Everything is held at zero while reset is asserted, regardless of the current state.
    assign bus.mem_req      = rst_n & w_mem_req;
    assign bus.mem_we       = rst_n & w_mem_we;
    assign bus.mem_addr_sel = rst_n & w_addr_sel;
    assign o_ir_write       = rst_n & w_ir_write;
    assign o_pc_write       = rst_n & w_pc_write;
    assign o_reg_write      = rst_n & w_reg_write;
    assign o_bus_err        = rst_n & w_bus_err;
    assign o_pc_src         = rst_n ? w_pc_src  : 2'd0;
    assign o_imm_sel        = rst_n ? w_imm_sel : 3'd0;
    assign o_alu_src_a      = rst_n ? w_src_a   : 2'd0;
    assign o_alu_src_b      = rst_n ? w_src_b   : 2'd0;
    assign o_alu_op         = rst_n ? w_alu_op  : 2'd0;
    assign o_wb_sel         = rst_n ? w_wb_sel  : 2'd0;
    assign o_state          = rst_n ? 3'(r_state) : 3'd0;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-instruction phase model feeding an expected-vector queue.
module tb_rv_multicycle_ctrl;

  localparam int T = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       bus_err;
    logic [2:0] state;
  } vec_t;

  localparam int W = $bits(vec_t);

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic branch_taken = 1'b0;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if bus ();
  logic       ir_write, pc_write, reg_write, bus_err;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] imm_sel, state_o;

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(T), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_instruction  (instruction),
    .i_branch_taken (branch_taken),
    .bus            (bus),
    .o_ir_write     (ir_write),
    .o_pc_write     (pc_write),
    .o_pc_src       (pc_src),
    .o_imm_sel      (imm_sel),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_alu_op       (alu_op),
    .o_reg_write    (reg_write),
    .o_wb_sel       (wb_sel),
    .o_bus_err      (bus_err),
    .o_state        (state_o)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           lat_q[$];
  int           lat_cnt = 0;
  int           n_vec = 0;
  int           n_err = 0;

  // model: what each phase of an instruction must look like
  function automatic int kind_of(input logic [31:0] ir);
    case (ir[6:0])
      7'h33: return K_R;
      7'h13: return K_I;
      7'h03: return K_LD;
      7'h23: return K_ST;
      7'h63: return K_BR;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input int k);
    case (k)
      K_ST: return 3'd1;
      K_BR: return 3'd2;
      K_LUI, K_AUIPC: return 3'd3;
      K_JAL: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic vec_t v_fetch(input bit ack, input bit to);
    vec_t v = '0;
    v.mem_req = 1'b1;
    v.ir_write = ack;
    v.pc_write = ack;
    v.bus_err = to & ~ack;
    v.state = 3'd0;
    return v;
  endfunction

  function automatic vec_t v_decode(input int k);
    vec_t v = '0;
    v.imm_sel = imm_of(k);
    v.state = 3'd1;
    return v;
  endfunction

  function automatic vec_t v_exec(input int k, input bit br);
    vec_t v = '0;
    v.imm_sel = imm_of(k);
    v.state = 3'd2;
    v.src_b = 2'd1;
    case (k)
      K_R:      begin v.src_b = 2'd0; v.alu_op = 2'd2; end
      K_I:      v.alu_op = 2'd2;
      K_BR:     begin v.src_a = 2'd1; v.pc_write = br; v.pc_src = br ? 2'd1 : 2'd0; end
      K_JAL:    begin v.src_a = 2'd1; v.pc_write = 1'b1; v.pc_src = 2'd1; end
      K_JALR:   begin v.pc_write = 1'b1; v.pc_src = 2'd2; end
      K_LUI:    v.src_a = 2'd2;
      K_AUIPC:  v.src_a = 2'd1;
      default:  v.src_a = 2'd0;
    endcase
    return v;
  endfunction

  function automatic vec_t v_mem(input int k, input bit ack, input bit to);
    vec_t v = '0;
    v.mem_req = 1'b1;
    v.addr_sel = 1'b1;
    v.mem_we = (k == K_ST);
    v.imm_sel = imm_of(k);
    v.bus_err = to & ~ack;
    v.state = 3'd3;
    return v;
  endfunction

  function automatic vec_t v_wb(input int k);
    vec_t v = '0;
    v.reg_write = 1'b1;
    v.wb_sel = (k == K_LD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
    v.imm_sel = imm_of(k);
    v.state = 3'd4;
    return v;
  endfunction

  function automatic vec_t v_trap();
    vec_t v = '0;
    v.state = 3'd5;
    return v;
  endfunction

  // driver tasks
  task automatic step(input bit rst, input bit ack, input bit br, input logic [31:0] ir,
                      input vec_t e, input string tag);
    @(posedge clk);
    #1;
    rst_n = rst;
    bus.mem_ack = ack;
    branch_taken = br;
    instruction = ir;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One request attempt: w idle-ack cycles then an ack, or a timeout abort when w >= T.
  task automatic req_phase(input bit is_mem, input int k, input int w, input logic [31:0] ir,
                           output bit ok);
    logic [31:0] irv;
    ok = 1'b0;
    for (int i = 0; i < T; i++) begin
      irv = is_mem ? ir : $urandom();
      if (i == w) begin
        step(1'b1, 1'b1, rbit(), irv, is_mem ? v_mem(k, 1'b1, 1'b0) : v_fetch(1'b1, 1'b0),
             is_mem ? "mem_ack" : "fetch_ack");
        ok = 1'b1;
        break;
      end else if (i == T - 1) begin
        step(1'b1, 1'b0, rbit(), irv, is_mem ? v_mem(k, 1'b0, 1'b1) : v_fetch(1'b0, 1'b1),
             is_mem ? "mem_timeout" : "fetch_timeout");
      end else begin
        step(1'b1, 1'b0, rbit(), irv, is_mem ? v_mem(k, 1'b0, 1'b0) : v_fetch(1'b0, 1'b0),
             is_mem ? "mem_wait" : "fetch_wait");
      end
    end
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(0, T - 1));
  endfunction

  // fetch_w / mem_w of -1 mean "pick randomly"; n_fto forced fetch timeouts come first.
  task automatic run_instr(input logic [31:0] ir, input int n_fto, input int fetch_w,
                           input int mem_w, input bit br);
    int k;
    bit ok;
    k = kind_of(ir);
    repeat (n_fto) req_phase(1'b0, k, T, ir, ok);
    if (fetch_w < 0) begin
      do req_phase(1'b0, k, rand_wait(), ir, ok); while (!ok);
    end else begin
      req_phase(1'b0, k, fetch_w, ir, ok);
    end
    step(1'b1, rbit(), rbit(), ir, v_decode(k), "decode");
    if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      repeat (5) step(1'b1, rbit(), rbit(), ir, v_trap(), "trap_hold");
      step(1'b0, rbit(), rbit(), ir, vec_t'('0), "trap_reset");
`endif
      return;
    end
    step(1'b1, rbit(), br, ir, v_exec(k, br), "exec");
    if (k == K_LD || k == K_ST) begin
      req_phase(1'b1, k, (mem_w < 0) ? rand_wait() : mem_w, ir, ok);
      if (k == K_LD && ok) step(1'b1, rbit(), rbit(), ir, v_wb(k), "wb_load");
    end else if (k != K_BR) begin
      step(1'b1, rbit(), rbit(), ir, v_wb(k), "wb");
    end
  endtask

  // compare process
  always @(negedge clk) begin
    logic [W-1:0] act_v;
    logic [W-1:0] exp_v;
    string tg;
    act_v = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write, pc_write, pc_src, imm_sel,
             alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, bus_err, state_o};
    if (rst_n) begin
      lat_cnt++;
      if (ir_write) begin
        lat_q.push_back(lat_cnt);
        lat_cnt = 0;
      end
    end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tg = tag_q.pop_front();
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL %s @%0t: got %h exp %h", tg, $time, act_v, exp_v);
      end
    end
  end

  // stimulus
  int exp_lat[10] = '{4, 3, 3, 4, 5, 8, 4, 4, 4, 4};
  logic [6:0] opcs[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                           7'h7F, 7'h73};

  initial begin
    logic [31:0] r;
    bus.mem_ack = 1'b0;

    repeat (3) step(1'b0, rbit(), rbit(), $urandom(), vec_t'('0), "reset");

    // Directed sequence with zero-wait fetches; the DUT-measured cycles between
    // consecutive fetch acks are checked against hand-counted latencies below.
    run_instr(32'h002081B3, 0, 0, 0, 1'b0);   // ADD x3,x1,x2
    run_instr(32'h00208463, 0, 0, 0, 1'b1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 0, 1'b0);   // BEQ not taken
    run_instr(32'h0020A223, 0, 0, 0, 1'b0);   // SW
    run_instr(32'h0080A283, 0, 0, 0, 1'b0);   // LW zero-wait
    run_instr(32'h0080A283, 0, 0, 3, 1'b0);   // LW, ack after 3 waits
    run_instr(32'hA000EC37, 0, 0, 0, 1'b0);   // LUI
    run_instr(32'h010000EF, 0, 0, 0, 1'b0);   // JAL
    run_instr(32'h000100E7, 0, 0, 0, 1'b0);   // JALR
    run_instr(32'h00000097, 0, 0, 0, 1'b0);   // AUIPC
    run_instr(32'h00100093, 0, 0, 0, 1'b0);   // ADDI
    @(negedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (lat_q.size() <= i + 1) begin
        n_err++;
        $display("FAIL latency[%0d]: no ir_write seen, required %0d cycles", i, exp_lat[i]);
      end else if (lat_q[i + 1] != exp_lat[i]) begin
        n_err++;
        $display("FAIL latency[%0d]: got %0d cycles, required %0d", i, lat_q[i + 1], exp_lat[i]);
      end
    end
    lat_q.delete();

    // Timeouts: two aborted fetches, then an ack exactly on the last allowed cycle.
    run_instr(32'h002081B3, 2, T - 1, 0, 1'b0);
    run_instr(32'h0080A283, 0, 0, T - 1, 1'b0);   // load acked on last allowed cycle
    run_instr(32'h0020A223, 0, 0, T, 1'b0);       // store abandoned by timeout
    run_instr(32'h0080A283, 1, 0, T, 1'b0);       // fetch timeout, then load abandoned

    // Reset in the middle of a store's memory phase.
    begin
      bit ok;
      req_phase(1'b0, K_ST, 0, 32'h0020A223, ok);
      step(1'b1, 1'b0, 1'b0, 32'h0020A223, v_decode(K_ST), "decode");
      step(1'b1, 1'b0, 1'b0, 32'h0020A223, v_exec(K_ST, 1'b0), "exec");
      repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0020A223, v_mem(K_ST, 1'b0, 1'b0), "mem_wait");
      repeat (2) step(1'b0, rbit(), rbit(), 32'h0020A223, vec_t'('0), "mid_mem_reset");
      run_instr(32'h002081B3, 0, 0, 0, 1'b0);
    end

    run_instr(32'h0000007F, 0, 0, 0, 1'b0);       // illegal opcode
    run_instr(32'h002081B3, 0, 0, 0, 1'b0);

    // Randomized program.
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      r[6:0] = opcs[$urandom_range(0, 10)];
      run_instr(r, 0, -1, -1, rbit());
    end

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
